// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants, the overlay transparency key and a small window helper.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_VIS_START = 144;
  localparam int DEF_H_VIS_END   = 784;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_VIS_START = 35;
  localparam int DEF_V_VIS_END   = 515;

  // Overlays subtract this origin to get visible-window coordinates.
  localparam logic [CNT_W-1:0] VIS_X0 = 10'(DEF_H_VIS_START);
  localparam logic [CNT_W-1:0] VIS_Y0 = 10'(DEF_V_VIS_START);

  // Sprite pixels of this colour are treated as transparent.
  localparam logic [11:0] WHITE = 12'hFFF;

  // Half-open interval test [lo, hi), unsigned.
  function automatic logic in_span(input logic [CNT_W-1:0] x,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// Pixel-rate divider: counts enabled clocks and flags the last clock of each pixel period.
module pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  // Holding while en is low keeps the partial pixel period intact across a pause.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, h/v counters, sync/bright decode and line/frame strobes.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_VIS_START = DEF_H_VIS_START,
  parameter int H_VIS_END   = DEF_H_VIS_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_VIS_START = DEF_V_VIS_START,
  parameter int V_VIS_END   = DEF_V_VIS_END
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = 10'(V_TOTAL - 1);

  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_next = h_wrap ? '0 : hCount + 10'd1;
    v_next = vCount;
    if (h_wrap) v_next = v_wrap ? '0 : vCount + 10'd1;
  end

  // Sync and bright decode the next counter values so they line up with the counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_en      <= 1'b0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hCount <= h_next;
        vCount <= v_next;
        hSync  <= (h_next >= 10'(H_SYNC));
        vSync  <= (v_next >= 10'(V_SYNC));
        bright <= in_span(h_next, 10'(H_VIS_START), 10'(H_VIS_END)) &&
                  in_span(v_next, 10'(V_VIS_START), 10'(V_VIS_END));
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int CLK_DIV     = 4;
  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 6;
  localparam int H_VIS_START = 10;
  localparam int H_VIS_END   = 36;
  localparam int V_TOTAL     = 20;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 4;
  localparam int V_VIS_END   = 17;
  localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;
  localparam int GOTO_LIMIT  = 2 * FRAME_TICKS * CLK_DIV;

  // clock / reset block
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       pix_en, hSync, vSync, bright, line_start, frame_start;
  logic [9:0] hCount, vCount;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .H_VIS_START(H_VIS_START), .H_VIS_END(H_VIS_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
    .V_VIS_START(V_VIS_START), .V_VIS_END(V_VIS_END)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_en(pix_en),
    .hCount(hCount), .vCount(vCount), .hSync(hSync), .vSync(vSync),
    .bright(bright), .line_start(line_start), .frame_start(frame_start)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position derived from the count of enabled clocks since reset.
  longint m_clks = 0;
  logic   m_pix  = 1'b0;
  int     m_h    = 0;
  int     m_v    = 0;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic br;
  } win_vec_t;

  win_vec_t win[9];

  function automatic logic [25:0] model_obs();
    logic hs, vs, br, ls, fs;
    hs = (m_h >= H_SYNC);
    vs = (m_v >= V_SYNC);
    br = (m_h >= H_VIS_START) && (m_h < H_VIS_END) &&
         (m_v >= V_VIS_START) && (m_v < V_VIS_END);
    ls = m_pix && (m_h == 0);
    fs = ls && (m_v == 0);
    return {m_pix, 10'(m_h), 10'(m_v), hs, vs, br, ls, fs};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock with the given inputs, model update, full-output compare
  task automatic step(input logic r, input logic e_in);
    logic [25:0] act, exp;
    rst = r;
    en  = e_in;
    @(posedge clk);
    if (!r) begin
      m_clks = 0;
      m_pix  = 1'b0;
    end else if (e_in) begin
      m_clks++;
      m_pix = ((m_clks % CLK_DIV) == 0);
    end else begin
      m_pix = 1'b0;
    end
    m_h = int'((m_clks / CLK_DIV) % H_TOTAL);
    m_v = int'((m_clks / CLK_DIV / H_TOTAL) % V_TOTAL);
    @(negedge clk);
    act = {pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start};
    exp = model_obs();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model_cycle: got pix=%b h=%0d v=%0d hs=%b vs=%b br=%b ls=%b fs=%b expected %h (got %h) at %0t",
               pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start, exp, act, $time);
    end
  endtask

  // Run until the model sits on the tick that lands on (h, v).
  task automatic goto(input int h, input int v);
    int guard = 0;
    do begin
      step(1'b1, 1'b1);
      guard++;
    end while (!(m_pix && m_h == h && m_v == v) && guard < GOTO_LIMIT);
    chk("goto_reached", int'(guard < GOTO_LIMIT), 1);
  endtask

  initial begin
    int n_pix, n_ls, n_fs, clks;

    win[0] = '{h: 5,  v: 1,  hs: 1'b0, vs: 1'b0, br: 1'b0};
    win[1] = '{h: 6,  v: 1,  hs: 1'b1, vs: 1'b0, br: 1'b0};
    win[2] = '{h: 10, v: 3,  hs: 1'b1, vs: 1'b1, br: 1'b0};
    win[3] = '{h: 9,  v: 4,  hs: 1'b1, vs: 1'b1, br: 1'b0};
    win[4] = '{h: 10, v: 4,  hs: 1'b1, vs: 1'b1, br: 1'b1};
    win[5] = '{h: 35, v: 4,  hs: 1'b1, vs: 1'b1, br: 1'b1};
    win[6] = '{h: 36, v: 4,  hs: 1'b1, vs: 1'b1, br: 1'b0};
    win[7] = '{h: 35, v: 16, hs: 1'b1, vs: 1'b1, br: 1'b1};
    win[8] = '{h: 10, v: 17, hs: 1'b1, vs: 1'b1, br: 1'b0};

    // reset with en high, then first pixel strobe on the 4th clock
    repeat (3) step(1'b0, 1'b1);
    chk("rst_hcount", int'(hCount), 0);
    chk("rst_vcount", int'(vCount), 0);
    chk("rst_outs", int'({pix_en, hSync, vSync, bright, line_start, frame_start}), 0);
    for (int i = 1; i < CLK_DIV; i++) begin
      step(1'b1, 1'b1);
      chk("first_pix_early", int'(pix_en), 0);
    end
    step(1'b1, 1'b1);
    chk("first_pix_en", int'(pix_en), 1);
    chk("first_hcount", int'(hCount), 1);

    // one full frame from reset
    step(1'b0, 1'b1);
    n_pix = 0; n_ls = 0; n_fs = 0;
    for (int i = 0; i < FRAME_TICKS * CLK_DIV; i++) begin
      step(1'b1, 1'b1);
      n_pix += int'(pix_en);
      n_ls  += int'(line_start);
      n_fs  += int'(frame_start);
    end
    chk("frame_pix_count", n_pix, FRAME_TICKS);
    chk("frame_ls_count", n_ls, V_TOTAL);
    chk("frame_fs_count", n_fs, 1);
    chk("frame_end_fs", int'(frame_start), 1);

    // line boundary
    goto(H_TOTAL - 1, 10);
    repeat (CLK_DIV) step(1'b1, 1'b1);
    chk("lb_pix_en", int'(pix_en), 1);
    chk("lb_hcount", int'(hCount), 0);
    chk("lb_vcount", int'(vCount), 11);
    chk("lb_line_start", int'(line_start), 1);
    chk("lb_frame_start", int'(frame_start), 0);

    // window and sync edges from the table
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      goto(win[i].h, win[i].v);
      chk("win_hcount", int'(hCount), win[i].h);
      chk("win_vcount", int'(vCount), win[i].v);
      chk("win_hsync", int'(hSync), int'(win[i].hs));
      chk("win_vsync", int'(vSync), int'(win[i].vs));
      chk("win_bright", int'(bright), int'(win[i].br));
    end

    // pause mid-pixel, then resume without a short or extra pixel
    goto(30, 17);
    repeat (2) step(1'b1, 1'b1);
    repeat (7) begin
      step(1'b1, 1'b0);
      chk("pause_hcount", int'(hCount), 30);
      chk("pause_pix_en", int'(pix_en), 0);
    end
    step(1'b1, 1'b1);
    chk("resume_wait", int'(pix_en), 0);
    step(1'b1, 1'b1);
    chk("resume_pix_en", int'(pix_en), 1);
    chk("resume_hcount", int'(hCount), 31);

    // reset mid-pixel mid-frame, then a full frame until the next frame_start
    goto(25, 18);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("mid_rst_zero", int'({pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start}), 0);
    n_pix = 0; clks = 0;
    do begin
      step(1'b1, 1'b1);
      clks++;
      n_pix += int'(pix_en);
    end while (!frame_start && clks < GOTO_LIMIT);
    chk("mid_rst_fs_ticks", n_pix, FRAME_TICKS);
    chk("mid_rst_fs_clks", clks, FRAME_TICKS * CLK_DIV);

    // randomized en pauses and occasional resets against the model
    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 599) != 0), logic'($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
